// File: rtl/alu_pkg.sv
// alu_pkg: shared width, sequencing states and constants for the ALU multicycle units
package alu_pkg;
    localparam int WIDTH = 32;
    localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract iteration on unsigned magnitudes
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic [W-1:0] quo_next
);
    logic [W:0] rem_sh;
    logic [W:0] trial;
    // A borrow out of the extra top bit means the trial went negative, so the remainder is restored
    always_comb begin
        rem_sh   = {rem, quo[W-1]};
        trial    = rem_sh - {1'b0, divisor};
        rem_next = trial[W] ? rem_sh[W-1:0] : trial[W-1:0];
        quo_next = {quo[W-2:0], ~trial[W]};
    end
endmodule

// File: rtl/iter_divider.sv
// iter_divider: multicycle signed divider, one quotient bit per clock; DIV_REMAINDER_EN exports the signed remainder
module iter_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
`ifdef DIV_REMAINDER_EN
   ,output logic [WIDTH-1:0] data_remainder
`endif
);
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d;
    logic [WIDTH-1:0] result_q, result_d, step_rem, step_quo, a_abs, b_abs;
    logic sq_q, sq_d, ovf_q, ovf_d, exc_q, exc_d;
`ifdef DIV_REMAINDER_EN
    logic sa_q, sa_d;
    logic [WIDTH-1:0] remout_q, remout_d;
`endif

    div_step #(.W(WIDTH)) u_step (
        .rem(rem_q), .quo(quo_q), .divisor(div_q),
        .rem_next(step_rem), .quo_next(step_quo)
    );

    // Next state: a start wins in every state (aborting any operation); otherwise iterate, sign-fix, pulse
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        sq_d     = sq_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = exc_q;
`ifdef DIV_REMAINDER_EN
        sa_d     = sa_q;
        remout_d = remout_q;
`endif
        a_abs = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        b_abs = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        if (ctrl_DIV) begin
            rem_d = '0;
            quo_d = a_abs;
            div_d = b_abs;
            cnt_d = '0;
            sq_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            ovf_d = (data_operandA == MIN_V) && (&data_operandB);
`ifdef DIV_REMAINDER_EN
            sa_d  = data_operandA[WIDTH-1];
`endif
            if (data_operandB == '0) begin
                state_d  = DONE;
                result_d = '0;
                exc_d    = 1'b1;
`ifdef DIV_REMAINDER_EN
                remout_d = '0;
`endif
            end else begin
                state_d = RUN;
                exc_d   = 1'b0;
            end
        end else begin
            case (state_q)
                RUN: begin
                    rem_d   = step_rem;
                    quo_d   = step_quo;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? FIX : RUN;
                end
                FIX: begin
                    result_d = sq_q ? -quo_q : quo_q;
                    exc_d    = ovf_q;
`ifdef DIV_REMAINDER_EN
                    remout_d = sa_q ? -rem_q : rem_q;
`endif
                    state_d  = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            sq_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
`ifdef DIV_REMAINDER_EN
            sa_q     <= 1'b0;
            remout_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            sq_q     <= sq_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
`ifdef DIV_REMAINDER_EN
            sa_q     <= sa_d;
            remout_q <= remout_d;
`endif
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q != IDLE);
`ifdef DIV_REMAINDER_EN
    assign data_remainder = remout_q;
`endif
endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: scoreboard bench for iter_divider; DIV_REMAINDER_EN also checks the remainder
module tb_iter_divider;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
`ifdef DIV_REMAINDER_EN
    logic [31:0] data_remainder;
`endif

    typedef struct {
        logic [31:0] r;
        logic        e;
        logic [31:0] rm;
        int          c;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    iter_divider dut (
        .clock(clock), .reset(reset), .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .data_result(data_result), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY), .busy(busy)
`ifdef DIV_REMAINDER_EN
       ,.data_remainder(data_remainder)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every ready pulse must match the oldest expectation, including its arrival cycle
    always @(negedge clock) begin
        if (data_resultRDY) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ready cyc=%0d result=%h", cyc, data_result);
            end else begin
                exp_t x;
                x = q.pop_front();
                tests++;
                if (data_result !== x.r) begin
                    fails++;
                    $display("FAIL result got=%h exp=%h", data_result, x.r);
                end
                tests++;
                if (data_exception !== x.e) begin
                    fails++;
                    $display("FAIL exception got=%b exp=%b", data_exception, x.e);
                end
                tests++;
                if (cyc != x.c) begin
                    fails++;
                    $display("FAIL latency ready_cyc=%0d exp_cyc=%0d", cyc, x.c);
                end
`ifdef DIV_REMAINDER_EN
                tests++;
                if (data_remainder !== x.rm) begin
                    fails++;
                    $display("FAIL remainder got=%h exp=%h", data_remainder, x.rm);
                end
`endif
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string name);
        check({name, "_result"}, data_result, 32'h0);
        check({name, "_exc"}, {31'b0, data_exception}, 32'h0);
        check({name, "_rdy"}, {31'b0, data_resultRDY}, 32'h0);
        check({name, "_busy"}, {31'b0, busy}, 32'h0);
`ifdef DIV_REMAINDER_EN
        check({name, "_rem"}, data_remainder, 32'h0);
`endif
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                         input logic e, input logic [31:0] rm, input int lat, input bit push);
        exp_t x;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV = 1'b1;
        x.r = r; x.e = e; x.rm = rm; x.c = cyc + lat;
        if (push) q.push_back(x);
        @(negedge clock);
        ctrl_DIV = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clock);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL timeout pending=%0d", q.size());
            q.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        #1;
        check_idle_zero("reset");
        repeat (2) @(negedge clock);
        reset = 1'b0;

        start(32'd100, 32'd7, 32'd14, 1'b0, 32'd2, 34, 1'b1);
        check("busy_run", {31'b0, busy}, 32'h1);
        drain();
        start(32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, 32'hFFFF_FFFE, 34, 1'b1);
        drain();
        start(32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 32'd2, 34, 1'b1);
        drain();
        start(32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 1'b0, 32'hFFFF_FFFF, 34, 1'b1);
        drain();
        start(32'd0, 32'd5, 32'd0, 1'b0, 32'd0, 34, 1'b1);
        drain();

        start(32'd5, 32'd0, 32'd0, 1'b1, 32'd0, 1, 1'b1);
        drain();
        check("busy_after_div0", {31'b0, busy}, 32'h0);
        check("exc_hold", {31'b0, data_exception}, 32'h1);

        start(32'd7, 32'hFFFF_FF9C, 32'd0, 1'b0, 32'd7, 34, 1'b1);
        check("exc_clear_on_start", {31'b0, data_exception}, 32'h0);
        drain();

        start(alu_pkg::INT_MIN, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'd0, 34, 1'b1);
        drain();

        start(32'd100, 32'd7, 32'd14, 1'b0, 32'd2, 34, 1'b0);
        repeat (8) @(negedge clock);
        start(32'd9, 32'd3, 32'd3, 1'b0, 32'd0, 34, 1'b1);
        drain();

        start(32'd100, 32'd7, 32'd14, 1'b0, 32'd2, 34, 1'b0);
        repeat (13) @(negedge clock);
        reset = 1'b1;
        #1;
        check_idle_zero("midop_reset");
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("no_ready_after_reset", {31'b0, busy}, 32'h0);

        start(32'd6, 32'd2, 32'd3, 1'b0, 32'd0, 34, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
